// File: rtl/icache_dm_if.sv
// rtl/icache_dm_if.sv - fetch-side and ROM-side signal bundle for icache_dm
interface icache_dm_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_instr;
  logic        cpu_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_rd;

  // Fetch stage plus instruction ROM, i.e. everything around the cache
  modport master (
    output cpu_req,
    output cpu_addr,
    output mem_rd,
    input  cpu_instr,
    input  cpu_ready,
    input  mem_addr
  );

  // The cache itself
  modport slave (
    input  cpu_req,
    input  cpu_addr,
    input  mem_rd,
    output cpu_instr,
    output cpu_ready,
    output mem_addr
  );
endinterface

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped icache, 0-cycle hits, line refill; ICACHE_PERF_CNT_EN adds hit/miss counters
module icache_dm #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  icache_dm_if.slave  bus
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OFF  = $clog2(LINE_WORDS);
  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = 32 - OFF - IDX;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t state, state_nx;

  logic [LINES-1:0] valid;
  logic [TAGW-1:0]  tags [LINES];
  logic [31:0]      data [LINES][LINE_WORDS];

  logic [OFF-1:0]   cnt;
  logic [31:0]      base;

  logic [OFF-1:0]   req_off;
  logic [IDX-1:0]   req_idx;
  logic [TAGW-1:0]  req_tag;
  logic [IDX-1:0]   fill_idx;
  logic [TAGW-1:0]  fill_tag;

  logic             hit;
  logic             miss_start;
  logic             fill_we;
  logic             fill_last;

  assign req_off  = bus.cpu_addr[OFF-1:0];
  assign req_idx  = bus.cpu_addr[OFF+IDX-1:OFF];
  assign req_tag  = bus.cpu_addr[31:OFF+IDX];
  // During refill the line being filled is identified by the latched base, not the live address
  assign fill_idx = base[OFF+IDX-1:OFF];
  assign fill_tag = base[31:OFF+IDX];

  assign hit = bus.cpu_req && valid[req_idx] && (tags[req_idx] == req_tag);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state, fetch-side outputs and ROM address
  always_comb begin
    state_nx      = state;
    bus.cpu_ready = 1'b0;
    bus.cpu_instr = 32'd0;
    bus.mem_addr  = 32'd0;
    miss_start    = 1'b0;
    fill_we       = 1'b0;
    fill_last     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cpu_req) begin
          if (hit) begin
            bus.cpu_ready = 1'b1;
            bus.cpu_instr = data[req_idx][req_off];
          end else begin
            miss_start = 1'b1;
            state_nx   = REFILL;
          end
        end
      end
      REFILL: begin
        bus.mem_addr = {base[31:OFF], cnt};
        fill_we      = 1'b1;
        if (cnt == {OFF{1'b1}}) begin
          fill_last = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Valid bits, refill word counter and latched line base
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      cnt   <= '0;
      base  <= '0;
    end else if (miss_start) begin
      base           <= {req_tag, req_idx, {OFF{1'b0}}};
      cnt            <= '0;
      valid[req_idx] <= 1'b0;
    end else if (fill_we) begin
      cnt <= cnt + 1'b1;
      if (fill_last) valid[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; a line is only trusted once its valid bit is set
  always_ff @(posedge clk) begin
    if (!reset && fill_we) begin
      data[fill_idx][cnt] <= bus.mem_rd;
      if (fill_last) tags[fill_idx] <= fill_tag;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  // Hit and miss event counters, free-running and wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (state == IDLE && bus.cpu_req && bus.cpu_ready) hit_count <= hit_count + 32'd1;
      if (miss_start) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
